// File: rtl/hsv_sched_pkg.sv
// Shared types and defaults for the two-requester hsv2rgb converter scheduler.
package hsv_sched_pkg;

    localparam int unsigned PIXEL_W = 24;

    // Field offsets inside a {H, S, V} pixel word
    localparam int unsigned H_LSB = 16;
    localparam int unsigned S_LSB = 8;
    localparam int unsigned V_LSB = 0;

    localparam int unsigned DEF_CONV_LAT   = 1;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    // Requester identifier: 0 or 1
    typedef logic req_id_t;

    // One stage of the tag pipe that shadows the converter
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/rgb_rsp_fifo.sv
// First-word-fall-through response FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module rgb_rsp_fifo
    import hsv_sched_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned WIDTH = PIXEL_W,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hsv_conv_sched.sv
// Round-robin scheduler sharing one pipelined hsv2rgb converter between two
// requesters, with credit-based issue into per-requester response FIFOs.
// Optional grant statistics are enabled by defining HSV_SCHED_STATS_EN.
module hsv_conv_sched
    import hsv_sched_pkg::*;
#(
    parameter int unsigned CONV_LAT   = DEF_CONV_LAT,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
`ifdef HSV_SCHED_STATS_EN
    ,
    parameter int unsigned STAT_W     = 16
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    input  logic [PIXEL_W-1:0] req0_hsv,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [PIXEL_W-1:0] req1_hsv,
    output logic               req1_ready,
    output logic               rsp0_valid,
    output logic [PIXEL_W-1:0] rsp0_rgb,
    input  logic               rsp0_ready,
    output logic               rsp1_valid,
    output logic [PIXEL_W-1:0] rsp1_rgb,
    input  logic               rsp1_ready,
    output logic [PIXEL_W-1:0] cv_hsv,
    input  logic [PIXEL_W-1:0] cv_rgb
`ifdef HSV_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat0_grants,
    output logic [STAT_W-1:0]  stat1_grants
`endif
);

    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_V = CW1'(FIFO_DEPTH);

    logic [1:0]         req_valid;
    logic [1:0]         rsp_ready;
    logic [1:0]         elig;
    logic [1:0]         grant;
    logic [1:0]         retire;
    logic [1:0]         fifo_empty;
    logic [PIXEL_W-1:0] req_hsv    [2];
    logic [PIXEL_W-1:0] rsp_rgb    [2];
    logic [CW-1:0]      fifo_count [2];
    logic [CW-1:0]      inflight   [2];
    req_id_t            last_grant;
    tag_t               tag_pipe   [CONV_LAT+1];

    assign req_valid  = {req1_valid, req0_valid};
    assign rsp_ready  = {rsp1_ready, rsp0_ready};
    assign req_hsv[0] = req0_hsv;
    assign req_hsv[1] = req1_hsv;

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = !fifo_empty[0];
    assign rsp1_valid = !fifo_empty[1];
    assign rsp0_rgb   = rsp_rgb[0];
    assign rsp1_rgb   = rsp_rgb[1];

    for (genvar i = 0; i < 2; i++) begin : g_req
        // Credit counts FIFO slots plus results still in the converter
        assign elig[i]   = req_valid[i] &&
                           (({1'b0, fifo_count[i]} + {1'b0, inflight[i]}) < DEPTH_V);
        assign retire[i] = tag_pipe[CONV_LAT].valid &&
                           (tag_pipe[CONV_LAT].id == req_id_t'(i));

        // In-flight tracking: up on issue, down on retire
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                inflight[i] <= '0;
            end else begin
                case ({grant[i], retire[i]})
                    2'b10:   inflight[i] <= inflight[i] + CW'(1);
                    2'b01:   inflight[i] <= inflight[i] - CW'(1);
                    default: inflight[i] <= inflight[i];
                endcase
            end
        end

        rgb_rsp_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (PIXEL_W)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (retire[i]),
            .din     (cv_rgb),
            .pop     (rsp_ready[i]),
            .dout    (rsp_rgb[i]),
            .empty   (fifo_empty[i]),
            .count   (fifo_count[i])
        );
    end

    // Round-robin grant; a tie goes to the requester not granted last
    always_comb begin
        grant = '0;
        if (reset_n) begin
            if (elig[0] && (!elig[1] || last_grant == 1'b1)) begin
                grant[0] = 1'b1;
            end else if (elig[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

    // Round-robin pointer, moves only when something is granted
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

    // Converter input register, holds its value when nothing is issued
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cv_hsv <= '0;
        end else if (grant[0]) begin
            cv_hsv <= req_hsv[0];
        end else if (grant[1]) begin
            cv_hsv <= req_hsv[1];
        end
    end

    // Tag pipe shadowing the converter latency
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k <= CONV_LAT; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: |grant, id: grant[1]};
            for (int unsigned k = 1; k <= CONV_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

`ifdef HSV_SCHED_STATS_EN
    // Saturating per-requester grant counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat0_grants <= '0;
            stat1_grants <= '0;
        end else begin
            if (grant[0] && stat0_grants != '1) begin
                stat0_grants <= stat0_grants + STAT_W'(1);
            end
            if (grant[1] && stat1_grants != '1) begin
                stat1_grants <= stat1_grants + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hsv_conv_sched.sv
// Bench for hsv_conv_sched: default instance (CONV_LAT=1) checked against a
// queue-based reference model, plus a CONV_LAT=3 instance.
module tb_hsv_conv_sched;

    localparam int unsigned LAT   = 1;
    localparam int unsigned LAT3  = 3;
    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [23:0] req0_hsv, req1_hsv;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [23:0] rsp0_rgb, rsp1_rgb, cv_hsv, cv_rgb;

    logic        l_req0_valid, l_req1_valid, l_req0_ready, l_req1_ready;
    logic [23:0] l_req0_hsv, l_req1_hsv;
    logic        l_rsp0_valid, l_rsp1_valid, l_rsp0_ready, l_rsp1_ready;
    logic [23:0] l_rsp0_rgb, l_rsp1_rgb, l_cv_hsv, l_cv_rgb;

`ifdef HSV_SCHED_STATS_EN
    logic [3:0]  stat0_grants, stat1_grants, l_stat0, l_stat1;
`endif

    hsv_conv_sched #(
        .CONV_LAT   (LAT),
        .FIFO_DEPTH (DEPTH)
`ifdef HSV_SCHED_STATS_EN
        , .STAT_W   (4)
`endif
    ) dut (
        .clk (clk), .reset_n (reset_n),
        .req0_valid (req0_valid), .req0_hsv (req0_hsv), .req0_ready (req0_ready),
        .req1_valid (req1_valid), .req1_hsv (req1_hsv), .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid), .rsp0_rgb (rsp0_rgb), .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid), .rsp1_rgb (rsp1_rgb), .rsp1_ready (rsp1_ready),
        .cv_hsv (cv_hsv), .cv_rgb (cv_rgb)
`ifdef HSV_SCHED_STATS_EN
        , .stat0_grants (stat0_grants), .stat1_grants (stat1_grants)
`endif
    );

    hsv_conv_sched #(
        .CONV_LAT   (LAT3),
        .FIFO_DEPTH (DEPTH)
`ifdef HSV_SCHED_STATS_EN
        , .STAT_W   (4)
`endif
    ) dut3 (
        .clk (clk), .reset_n (reset_n),
        .req0_valid (l_req0_valid), .req0_hsv (l_req0_hsv), .req0_ready (l_req0_ready),
        .req1_valid (l_req1_valid), .req1_hsv (l_req1_hsv), .req1_ready (l_req1_ready),
        .rsp0_valid (l_rsp0_valid), .rsp0_rgb (l_rsp0_rgb), .rsp0_ready (l_rsp0_ready),
        .rsp1_valid (l_rsp1_valid), .rsp1_rgb (l_rsp1_rgb), .rsp1_ready (l_rsp1_ready),
        .cv_hsv (l_cv_hsv), .cv_rgb (l_cv_rgb)
`ifdef HSV_SCHED_STATS_EN
        , .stat0_grants (l_stat0), .stat1_grants (l_stat1)
`endif
    );

    // Converter models: output is the bitwise inverse after LAT cycles
    logic [23:0] cv_pipe  [LAT];
    logic [23:0] cv_pipe3 [LAT3];
    always @(posedge clk) begin
        cv_pipe[0] <= ~cv_hsv;
        for (int k = 1; k < LAT; k++) cv_pipe[k] <= cv_pipe[k-1];
        cv_pipe3[0] <= ~l_cv_hsv;
        for (int k = 1; k < LAT3; k++) cv_pipe3[k] <= cv_pipe3[k-1];
    end
    assign cv_rgb   = cv_pipe[LAT-1];
    assign l_cv_rgb = cv_pipe3[LAT3-1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: per requester, a queue of accepted-but-unpopped
    // pixels with the cycle at which each becomes visible at the response port.
    typedef struct {
        logic [23:0] rgb;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic        m_last;
    int          cyc;
    int          n_vec;
    int          n_err;
    logic [1:0]  obs_acc, obs_pop, obs_rdy, obs_rv;
    logic [23:0] obs_hsv0, obs_hsv1, obs_rgb0;

    // One clock cycle: compare mid-cycle, then advance the model on the edge
    task automatic step();
        logic e0, e1, x_rdy0, x_rdy1, x_v0, x_v1;
        #4;
        e0     = reset_n && req0_valid && (q0.size() < DEPTH);
        e1     = reset_n && req1_valid && (q1.size() < DEPTH);
        x_rdy0 = e0 && (!e1 || m_last == 1'b1);
        x_rdy1 = e1 && !x_rdy0;
        x_v0   = (q0.size() > 0) && (q0[0].due <= cyc);
        x_v1   = (q1.size() > 0) && (q1[0].due <= cyc);
        n_vec += 4;
        if (req0_ready !== x_rdy0) begin
            n_err++; $display("FAIL ready0 cyc=%0d got=%b exp=%b", cyc, req0_ready, x_rdy0);
        end
        if (req1_ready !== x_rdy1) begin
            n_err++; $display("FAIL ready1 cyc=%0d got=%b exp=%b", cyc, req1_ready, x_rdy1);
        end
        if (rsp0_valid !== x_v0) begin
            n_err++; $display("FAIL rsp0_valid cyc=%0d got=%b exp=%b", cyc, rsp0_valid, x_v0);
        end
        if (rsp1_valid !== x_v1) begin
            n_err++; $display("FAIL rsp1_valid cyc=%0d got=%b exp=%b", cyc, rsp1_valid, x_v1);
        end
        if (x_v0) begin
            n_vec++;
            if (rsp0_rgb !== q0[0].rgb) begin
                n_err++; $display("FAIL rsp0_rgb cyc=%0d got=%h exp=%h", cyc, rsp0_rgb, q0[0].rgb);
            end
        end
        if (x_v1) begin
            n_vec++;
            if (rsp1_rgb !== q1[0].rgb) begin
                n_err++; $display("FAIL rsp1_rgb cyc=%0d got=%h exp=%h", cyc, rsp1_rgb, q1[0].rgb);
            end
        end
        obs_rdy  = {req1_ready, req0_ready};
        obs_rv   = {rsp1_valid, rsp0_valid};
        obs_acc  = {req1_valid && req1_ready, req0_valid && req0_ready};
        obs_pop  = {rsp1_valid && rsp1_ready, rsp0_valid && rsp0_ready};
        obs_hsv0 = req0_hsv;
        obs_hsv1 = req1_hsv;
        obs_rgb0 = rsp0_rgb;
        @(posedge clk);
        if (!reset_n) begin
            q0.delete();
            q1.delete();
            m_last = 1'b1;
        end else begin
            if (obs_pop[0] && q0.size() > 0) q0.delete(0);
            if (obs_pop[1] && q1.size() > 0) q1.delete(0);
            if (obs_acc[0]) begin
                n_vec++;
                if (q0.size() >= DEPTH) begin
                    n_err++; $display("FAIL overflow0 cyc=%0d got=%0d exp<%0d", cyc, q0.size(), DEPTH);
                end
                q0.push_back('{rgb: ~obs_hsv0, due: cyc + 2 + LAT});
            end
            if (obs_acc[1]) begin
                n_vec++;
                if (q1.size() >= DEPTH) begin
                    n_err++; $display("FAIL overflow1 cyc=%0d got=%0d exp<%0d", cyc, q1.size(), DEPTH);
                end
                q1.push_back('{rgb: ~obs_hsv1, due: cyc + 2 + LAT});
            end
            if (obs_acc[1]) m_last = 1'b1;
            else if (obs_acc[0]) m_last = 1'b0;
        end
        cyc++;
        #1;
        if (obs_acc[0]) req0_hsv = 24'($urandom);
        if (obs_acc[1]) req1_hsv = 24'($urandom);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        step();
        n_vec++;
        if (cv_hsv !== 24'h0) begin
            n_err++; $display("FAIL reset_cv_hsv got=%h exp=000000", cv_hsv);
        end
        reset_n = 1'b1;
        step();
        n_vec++;
        if (obs_acc !== 2'b01) begin
            n_err++; $display("FAIL reset_first_grant got=%b exp=01", obs_acc);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_single();
        int lat;
        logic got;
        logic saw1;
        do_reset();
        req0_valid = 1'b1;
        req0_hsv   = 24'h123456;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = obs_acc[0];
        end
        req0_valid = 1'b0;
        n_vec++;
        if (!got) begin
            n_err++; $display("FAIL single_accept got=0 exp=1");
        end
        lat  = 0;
        saw1 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (obs_rv[0] && lat == 0) begin
                lat = k;
                n_vec++;
                if (obs_rgb0 !== 24'hEDCBA9) begin
                    n_err++; $display("FAIL single_rgb got=%h exp=edcba9", obs_rgb0);
                end
            end
            if (obs_rv[1]) saw1 = 1'b1;
        end
        n_vec += 2;
        if (lat != 2 + LAT) begin
            n_err++; $display("FAIL single_latency got=%0d exp=%0d", lat, 2 + LAT);
        end
        if (saw1) begin
            n_err++; $display("FAIL single_rsp1 got=1 exp=0");
        end
    endtask

    task automatic test_tie();
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            n_vec++;
            if (obs_acc[i % 2] !== 1'b1 || obs_acc[1 - (i % 2)] !== 1'b0) begin
                n_err++; $display("FAIL tie_seq i=%0d got=%b exp_grant=%0d", i, obs_acc, i % 2);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_backpressure();
        int acc1;
        int acc0_late;
        do_reset();
        rsp1_ready = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        acc1 = 0;
        acc0_late = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (obs_acc[1]) acc1++;
            if (i >= 8 && obs_acc[0]) acc0_late++;
        end
        n_vec += 3;
        if (acc1 != DEPTH) begin
            n_err++; $display("FAIL bp_accepts1 got=%0d exp=%0d", acc1, DEPTH);
        end
        if (acc0_late != 6) begin
            n_err++; $display("FAIL bp_rate0 got=%0d exp=6", acc0_late);
        end
        if (obs_rdy[1] !== 1'b0) begin
            n_err++; $display("FAIL bp_ready1_low got=%b exp=0", obs_rdy[1]);
        end
        rsp1_ready = 1'b1;
        step();
        n_vec += 2;
        if (obs_pop[1] !== 1'b1) begin
            n_err++; $display("FAIL bp_pop got=%b exp=1", obs_pop[1]);
        end
        if (obs_rdy[1] !== 1'b0) begin
            n_err++; $display("FAIL bp_ready_same_cycle got=%b exp=0", obs_rdy[1]);
        end
        rsp1_ready = 1'b0;
        step();
        n_vec++;
        if (obs_rdy[1] !== 1'b1) begin
            n_err++; $display("FAIL bp_ready_next_cycle got=%b exp=1", obs_rdy[1]);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp1_ready = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_reset_midflight();
        int lat;
        int cnt;
        logic seen;
        do_reset();
        req0_valid = 1'b1;
        step();
        step();
        n_vec++;
        if (obs_acc[0] !== 1'b1) begin
            n_err++; $display("FAIL mid_accept got=%b exp=1", obs_acc[0]);
        end
        req0_valid = 1'b0;
        reset_n    = 1'b0;
        step();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (obs_rv !== 2'b00) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++; $display("FAIL mid_stale_rsp got=1 exp=0");
        end
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (obs_rv[0] && lat == 0) lat = k;
        end
        n_vec++;
        if (lat != 2 + LAT) begin
            n_err++; $display("FAIL mid_latency got=%0d exp=%0d", lat, 2 + LAT);
        end
        rsp0_ready = 1'b0;
        req0_valid = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (obs_acc[0]) cnt++;
        end
        n_vec++;
        if (cnt != DEPTH) begin
            n_err++; $display("FAIL mid_credit got=%0d exp=%0d", cnt, DEPTH);
        end
        req0_valid = 1'b0;
        rsp0_ready = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 9) < 7);
            req1_valid = ($urandom_range(0, 9) < 7);
            rsp0_ready = ($urandom_range(0, 9) < 6);
            rsp1_ready = ($urandom_range(0, 9) < 6);
            reset_n    = ($urandom_range(0, 79) != 0);
            step();
        end
        reset_n    = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_latency_param();
        exp_t lq[$];
        int   acc_cyc[$];
        int   nrsp;
        logic acc;
        do_reset();
        l_req0_valid = 1'b1;
        l_req0_hsv   = 24'($urandom);
        nrsp = 0;
        for (int c = 0; c < 45; c++) begin
            if (c >= 32) l_req0_valid = 1'b0;
            #4;
            n_vec++;
            if (l_rsp1_valid !== 1'b0 || l_req1_ready !== 1'b0) begin
                n_err++; $display("FAIL lat3_req1_idle c=%0d got=%b%b exp=00", c, l_rsp1_valid, l_req1_ready);
            end
            if (l_rsp0_valid === 1'b1) begin
                n_vec++;
                if (lq.size() == 0) begin
                    n_err++; $display("FAIL lat3_spurious c=%0d got=1 exp=0", c);
                end else begin
                    if (l_rsp0_rgb !== lq[0].rgb || c != lq[0].due) begin
                        n_err++; $display("FAIL lat3_rsp c=%0d got=%h exp=%h due=%0d", c, l_rsp0_rgb, lq[0].rgb, lq[0].due);
                    end
                    lq.delete(0);
                    nrsp++;
                end
            end
            acc = l_req0_valid && l_req0_ready;
            if (acc) begin
                n_vec++;
                if (lq.size() >= DEPTH) begin
                    n_err++; $display("FAIL lat3_overflow c=%0d got=%0d exp<%0d", c, lq.size(), DEPTH);
                end
                lq.push_back('{rgb: ~l_req0_hsv, due: c + 2 + LAT3});
                acc_cyc.push_back(c);
            end
            @(posedge clk);
            #1;
            if (acc) l_req0_hsv = 24'($urandom);
        end
        n_vec += 3;
        if (nrsp < 8) begin
            n_err++; $display("FAIL lat3_count got=%0d exp>=8", nrsp);
        end
        if (lq.size() != 0) begin
            n_err++; $display("FAIL lat3_drain got=%0d exp=0", lq.size());
        end
        if (acc_cyc.size() < 4 || acc_cyc[3] != acc_cyc[0] + 3) begin
            n_err++; $display("FAIL lat3_b2b got=%0d accepts exp=4 consecutive", acc_cyc.size());
        end
    endtask

`ifdef HSV_SCHED_STATS_EN
    task automatic test_stats();
        int n;
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 80 && n < 20; i++) begin
            step();
            if (obs_acc[0]) begin
                n++;
                if (n == 10) begin
                    n_vec++;
                    if (stat0_grants !== 4'd10) begin
                        n_err++; $display("FAIL stats_mid got=%0d exp=10", stat0_grants);
                    end
                end
            end
        end
        req0_valid = 1'b0;
        n_vec += 3;
        if (n != 20) begin
            n_err++; $display("FAIL stats_grants got=%0d exp=20", n);
        end
        if (stat0_grants !== 4'hF) begin
            n_err++; $display("FAIL stats_sat got=%0d exp=15", stat0_grants);
        end
        if (stat1_grants !== 4'h0) begin
            n_err++; $display("FAIL stats_other got=%0d exp=0", stat1_grants);
        end
        repeat (6) step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        m_last = 1'b1;
        reset_n    = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_hsv   = 24'($urandom);
        req1_hsv   = 24'($urandom);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        l_req0_valid = 1'b0;
        l_req1_valid = 1'b0;
        l_req0_hsv   = '0;
        l_req1_hsv   = '0;
        l_rsp0_ready = 1'b1;
        l_rsp1_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_reset_midflight();
        test_random();
        test_latency_param();
`ifdef HSV_SCHED_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
